// File: rtl/ex_trace_scheduler_pkg.sv
// Shared types for the EX-stage trace scheduler: the trace element carried end to end
// and the per-lane slot state.
package ex_trace_scheduler_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] info;
        logic        passthrough;
    } trace_output;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        HOLD = 2'b10
    } lane_state_t;

    // Pointer width for an index space of n entries; never narrower than one bit.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ex_trace_scheduler_if.sv
// Bundle of ID-side input, lane dispatch/completion bus, in-order output and status flags.
interface ex_trace_scheduler_if
    import ex_trace_scheduler_pkg::*;
#(
    parameter int NUM_LANES               = 2,
    parameter int PROCESSING_QUEUE_LENGTH = 4,
    parameter int DROP_CNT_WIDTH          = 16
);

    localparam int OCC_W = $clog2(PROCESSING_QUEUE_LENGTH + 1);

    logic                              id_data_ready;
    trace_output                       id_data_i;
    logic        [NUM_LANES-1:0]       lane_start;
    trace_output                       lane_data_o;
    logic        [NUM_LANES-1:0]       lane_done;
    trace_output [NUM_LANES-1:0]       lane_data_i;
    logic                              ex_data_ready;
    trace_output                       ex_data_o;
    logic        [OCC_W-1:0]           occupancy;
    logic                              overflow;
    logic        [DROP_CNT_WIDTH-1:0]  drop_count;
    logic                              protocol_err;

    modport slave (
        input  id_data_ready, id_data_i, lane_done, lane_data_i,
        output lane_start, lane_data_o, ex_data_ready, ex_data_o,
               occupancy, overflow, drop_count, protocol_err
    );

    modport master (
        output id_data_ready, id_data_i, lane_done, lane_data_i,
        input  lane_start, lane_data_o, ex_data_ready, ex_data_o,
               occupancy, overflow, drop_count, protocol_err
    );

endinterface

// File: rtl/ex_lane_slot.sv
// One EX lane as seen by the scheduler: tracks whether the lane is working, and holds
// its finished element until the in-order retire pointer reaches it.
//
// state | meaning
// IDLE  | lane free, may be dispatched
// BUSY  | element handed to the lane, waiting for done
// HOLD  | result captured, waiting for in-order retire
module ex_lane_slot
    import ex_trace_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        done,
    input  trace_output data_i,
    input  logic        retire,
    output lane_state_t state,
    output trace_output data_o,
    output logic        err
);

    lane_state_t state_q;
    trace_output data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) state_q <= BUSY;
                BUSY: begin
                    if (done) begin
                        state_q <= HOLD;
                        data_q  <= data_i;
                    end
                end
                HOLD: if (retire) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // A completion is only meaningful while the lane owns an element.
    assign err    = done && (state_q != BUSY);
    assign state  = state_q;
    assign data_o = data_q;

endmodule

// File: rtl/ex_trace_scheduler.sv
// In-order trace element scheduler: queues ID elements, dispatches them round-robin to
// EX lanes and re-emits lane results in dispatch order.
module ex_trace_scheduler
    import ex_trace_scheduler_pkg::*;
#(
    parameter int NUM_LANES               = 2,
    parameter int PROCESSING_QUEUE_LENGTH = 4,
    parameter int DROP_CNT_WIDTH          = 16
)(
    input logic                  clk,
    input logic                  rst,
    ex_trace_scheduler_if.slave  bus
);

    localparam int QD = PROCESSING_QUEUE_LENGTH;
    localparam int PW = ptr_w(QD);
    localparam int LW = ptr_w(NUM_LANES);
    localparam int OW = $clog2(QD + 1);

    localparam logic [PW-1:0] HEAD_LAST = PW'(QD - 1);
    localparam logic [LW-1:0] LANE_LAST = LW'(NUM_LANES - 1);
    localparam logic [OW-1:0] DEPTH_C   = OW'(QD);

    trace_output                      mem_q [QD];
    logic        [PW-1:0]             head_q, tail_q;
    logic        [OW-1:0]             count_q;
    logic        [LW-1:0]             disp_ptr_q, ret_ptr_q;
    logic                             overflow_q, perr_q;
    logic        [DROP_CNT_WIDTH-1:0] drop_q;
    trace_output                      lane_last_q, ex_last_q;

    lane_state_t                      slot_state [NUM_LANES];
    trace_output                      slot_data  [NUM_LANES];
    logic        [NUM_LANES-1:0]      slot_err;
    logic        [NUM_LANES-1:0]      start_vec, retire_vec;

    logic disp_fire, ret_fire, enq, drop;

    // Strict round-robin on both sides: a busy lane stalls dispatch rather than being
    // skipped, which is what keeps retire order equal to dispatch order.
    assign disp_fire = (count_q != '0) && (slot_state[disp_ptr_q] == IDLE);
    assign ret_fire  = (slot_state[ret_ptr_q] == HOLD);
    assign enq       = bus.id_data_ready && ((count_q < DEPTH_C) || disp_fire);
    assign drop      = bus.id_data_ready && !enq;

    always_comb begin
        start_vec  = '0;
        retire_vec = '0;
        if (disp_fire) start_vec[disp_ptr_q] = 1'b1;
        if (ret_fire)  retire_vec[ret_ptr_q] = 1'b1;
    end

    // Queue storage needs no reset: only entries below count_q are ever read out.
    always_ff @(posedge clk) begin
        if (enq) mem_q[tail_q] <= bus.id_data_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            disp_ptr_q  <= '0;
            ret_ptr_q   <= '0;
            overflow_q  <= 1'b0;
            perr_q      <= 1'b0;
            drop_q      <= '0;
            lane_last_q <= '0;
            ex_last_q   <= '0;
        end else begin
            if (enq) tail_q <= (tail_q == HEAD_LAST) ? '0 : tail_q + 1'b1;
            if (disp_fire) begin
                head_q      <= (head_q == HEAD_LAST) ? '0 : head_q + 1'b1;
                disp_ptr_q  <= (disp_ptr_q == LANE_LAST) ? '0 : disp_ptr_q + 1'b1;
                lane_last_q <= mem_q[head_q];
            end
            if (enq && !disp_fire) begin
                count_q <= count_q + 1'b1;
            end else if (!enq && disp_fire) begin
                count_q <= count_q - 1'b1;
            end
            if (ret_fire) begin
                ret_ptr_q <= (ret_ptr_q == LANE_LAST) ? '0 : ret_ptr_q + 1'b1;
                ex_last_q <= slot_data[ret_ptr_q];
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != '1) drop_q <= drop_q + 1'b1;
            end
            if (|slot_err) perr_q <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        ex_lane_slot u_slot (
            .clk    (clk),
            .rst    (rst),
            .start  (start_vec[g]),
            .done   (bus.lane_done[g]),
            .data_i (bus.lane_data_i[g]),
            .retire (retire_vec[g]),
            .state  (slot_state[g]),
            .data_o (slot_data[g]),
            .err    (slot_err[g])
        );
    end

    // Data buses show the live element on a strobe and otherwise keep the last one sent.
    assign bus.lane_start    = start_vec;
    assign bus.lane_data_o   = disp_fire ? mem_q[head_q] : lane_last_q;
    assign bus.ex_data_ready = ret_fire;
    assign bus.ex_data_o     = ret_fire ? slot_data[ret_ptr_q] : ex_last_q;
    assign bus.occupancy     = count_q;
    assign bus.overflow      = overflow_q;
    assign bus.drop_count    = drop_q;
    assign bus.protocol_err  = perr_q;

endmodule

// File: tb/tb_ex_trace_scheduler.sv
// Scenario bench for ex_trace_scheduler: directed cases plus a randomized run checked
// against an in-flight list model of program order.
module tb_ex_trace_scheduler;
    import ex_trace_scheduler_pkg::*;

    localparam int NL = 2;
    localparam int QD = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    ex_trace_scheduler_if #(.NUM_LANES(NL), .PROCESSING_QUEUE_LENGTH(QD), .DROP_CNT_WIDTH(DW)) bus ();

    ex_trace_scheduler #(.NUM_LANES(NL), .PROCESSING_QUEUE_LENGTH(QD), .DROP_CNT_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        trace_output e;
        trace_output r;
        int          lane;
        bit          done;
    } infl_t;

    function automatic trace_output mk(input int n);
        trace_output t;
        t.addr        = 32'h1000_0000 + 32'(n);
        t.info        = 16'(n * 7 + 3);
        t.passthrough = (n % 5) == 0;
        return t;
    endfunction

    // What a lane hands back for an element it was given.
    function automatic trace_output xf(input trace_output e);
        trace_output r;
        r      = e;
        r.addr = e.addr + 32'd4;
        r.info = e.info ^ 16'hA5A5;
        return r;
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        bus.id_data_ready = 1'b0;
        bus.id_data_i     = '0;
        bus.lane_done     = '0;
        bus.lane_data_i   = '0;
    endtask

    task automatic do_reset();
        clr_inputs();
        rst = 1'b0;
        next_cyc();
        next_cyc();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        clr_inputs();
        #2;
        n_checks++; if (bus.lane_start !== 2'b00) begin n_err++; $display("FAIL rst_lane_start got=%b exp=00", bus.lane_start); end
        n_checks++; if (bus.ex_data_ready !== 1'b0) begin n_err++; $display("FAIL rst_ex_ready got=%b exp=0", bus.ex_data_ready); end
        n_checks++; if (bus.occupancy !== 3'd0) begin n_err++; $display("FAIL rst_occupancy got=%0d exp=0", bus.occupancy); end
        n_checks++; if ({bus.overflow, bus.protocol_err} !== 2'b00) begin n_err++; $display("FAIL rst_flags got=%b exp=00", {bus.overflow, bus.protocol_err}); end
        n_checks++; if (bus.drop_count !== 16'd0) begin n_err++; $display("FAIL rst_drop_count got=%0d exp=0", bus.drop_count); end
        n_checks++; if ({bus.lane_data_o, bus.ex_data_o} !== '0) begin n_err++; $display("FAIL rst_data_buses got=%h exp=0", {bus.lane_data_o, bus.ex_data_o}); end
        do_reset();
        #2;
        n_checks++; if ({bus.lane_start, bus.ex_data_ready} !== 3'b000) begin n_err++; $display("FAIL rst_release_strobes got=%b exp=000", {bus.lane_start, bus.ex_data_ready}); end
    endtask

    task automatic test_single();
        trace_output a;
        a = mk(1);
        do_reset();
        bus.id_data_ready = 1'b1; bus.id_data_i = a; #2;
        n_checks++; if (bus.lane_start !== 2'b00) begin n_err++; $display("FAIL single_no_bypass got=%b exp=00", bus.lane_start); end
        next_cyc();
        bus.id_data_ready = 1'b0; #2;
        n_checks++; if (bus.lane_start !== 2'b01) begin n_err++; $display("FAIL single_start got=%b exp=01", bus.lane_start); end
        n_checks++; if (bus.lane_data_o !== a) begin n_err++; $display("FAIL single_lane_data got=%h exp=%h", bus.lane_data_o, a); end
        n_checks++; if (bus.occupancy !== 3'd1) begin n_err++; $display("FAIL single_occ1 got=%0d exp=1", bus.occupancy); end
        next_cyc(); #2;
        n_checks++; if ({bus.lane_start, bus.occupancy} !== 5'b00_000) begin n_err++; $display("FAIL single_after_disp got=%b exp=00000", {bus.lane_start, bus.occupancy}); end
        next_cyc();
        next_cyc();
        bus.lane_done = 2'b01; bus.lane_data_i[0] = xf(a); #2;
        n_checks++; if (bus.ex_data_ready !== 1'b0) begin n_err++; $display("FAIL single_no_early_retire got=%b exp=0", bus.ex_data_ready); end
        next_cyc();
        bus.lane_done = 2'b00; #2;
        n_checks++; if (bus.ex_data_ready !== 1'b1) begin n_err++; $display("FAIL single_retire got=%b exp=1", bus.ex_data_ready); end
        n_checks++; if (bus.ex_data_o !== xf(a)) begin n_err++; $display("FAIL single_ex_data got=%h exp=%h", bus.ex_data_o, xf(a)); end
        next_cyc(); #2;
        n_checks++; if (bus.ex_data_ready !== 1'b0) begin n_err++; $display("FAIL single_one_shot got=%b exp=0", bus.ex_data_ready); end
        n_checks++; if (bus.ex_data_o !== xf(a)) begin n_err++; $display("FAIL single_ex_hold got=%h exp=%h", bus.ex_data_o, xf(a)); end
    endtask

    task automatic test_order();
        trace_output a, b, c;
        a = mk(2); b = mk(3); c = mk(4);
        do_reset();
        bus.id_data_ready = 1'b1; bus.id_data_i = a; next_cyc();
        bus.id_data_i = b; #2;
        n_checks++; if (bus.lane_start !== 2'b01 || bus.lane_data_o !== a) begin n_err++; $display("FAIL order_disp_a got=%b/%h exp=01/%h", bus.lane_start, bus.lane_data_o, a); end
        next_cyc();
        bus.id_data_i = c; #2;
        n_checks++; if (bus.lane_start !== 2'b10 || bus.lane_data_o !== b) begin n_err++; $display("FAIL order_disp_b got=%b/%h exp=10/%h", bus.lane_start, bus.lane_data_o, b); end
        next_cyc();
        bus.id_data_ready = 1'b0; bus.lane_done = 2'b10; bus.lane_data_i[1] = xf(b); #2;
        n_checks++; if (bus.lane_start !== 2'b00 || bus.occupancy !== 3'd1) begin n_err++; $display("FAIL order_c_waits got=%b/%0d exp=00/1", bus.lane_start, bus.occupancy); end
        next_cyc();
        bus.lane_done = 2'b01; bus.lane_data_i[0] = xf(a); #2;
        n_checks++; if (bus.ex_data_ready !== 1'b0) begin n_err++; $display("FAIL order_b_held got=%b exp=0", bus.ex_data_ready); end
        next_cyc();
        bus.lane_done = 2'b00; #2;
        n_checks++; if (bus.ex_data_ready !== 1'b1 || bus.ex_data_o !== xf(a)) begin n_err++; $display("FAIL order_first_a got=%b/%h exp=1/%h", bus.ex_data_ready, bus.ex_data_o, xf(a)); end
        n_checks++; if (bus.lane_start !== 2'b00) begin n_err++; $display("FAIL order_c_before_free got=%b exp=00", bus.lane_start); end
        next_cyc(); #2;
        n_checks++; if (bus.ex_data_ready !== 1'b1 || bus.ex_data_o !== xf(b)) begin n_err++; $display("FAIL order_second_b got=%b/%h exp=1/%h", bus.ex_data_ready, bus.ex_data_o, xf(b)); end
        n_checks++; if (bus.lane_start !== 2'b01 || bus.lane_data_o !== c) begin n_err++; $display("FAIL order_disp_c got=%b/%h exp=01/%h", bus.lane_start, bus.lane_data_o, c); end
        next_cyc();
        bus.lane_done = 2'b01; bus.lane_data_i[0] = xf(c); #2;
        n_checks++; if (bus.ex_data_ready !== 1'b0) begin n_err++; $display("FAIL order_gap got=%b exp=0", bus.ex_data_ready); end
        next_cyc();
        bus.lane_done = 2'b00; #2;
        n_checks++; if (bus.ex_data_ready !== 1'b1 || bus.ex_data_o !== xf(c)) begin n_err++; $display("FAIL order_third_c got=%b/%h exp=1/%h", bus.ex_data_ready, bus.ex_data_o, xf(c)); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus.id_data_ready = 1'b1; bus.id_data_i = mk(10 + i); next_cyc();
        end
        bus.id_data_i = mk(16); #2;
        n_checks++; if (bus.occupancy !== 3'd4 || bus.drop_count !== 16'd0 || bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_six_queued got=occ%0d/drop%0d/ovf%b exp=occ4/drop0/ovf0", bus.occupancy, bus.drop_count, bus.overflow); end
        next_cyc();
        bus.id_data_i = mk(17); #2;
        n_checks++; if (bus.drop_count !== 16'd1) begin n_err++; $display("FAIL ovf_first_drop got=%0d exp=1", bus.drop_count); end
        next_cyc();
        bus.id_data_ready = 1'b0; #2;
        n_checks++; if (bus.drop_count !== 16'd2 || bus.overflow !== 1'b1 || bus.occupancy !== 3'd4) begin n_err++; $display("FAIL ovf_two_drops got=drop%0d/ovf%b/occ%0d exp=drop2/ovf1/occ4", bus.drop_count, bus.overflow, bus.occupancy); end
    endtask

    // Continues from the full queue left by test_overflow.
    task automatic test_full_accept();
        bus.lane_done = 2'b01; bus.lane_data_i[0] = xf(mk(10));
        next_cyc();
        bus.lane_done = 2'b00; #2;
        n_checks++; if (bus.ex_data_ready !== 1'b1 || bus.ex_data_o !== xf(mk(10))) begin n_err++; $display("FAIL full_retire got=%b/%h exp=1/%h", bus.ex_data_ready, bus.ex_data_o, xf(mk(10))); end
        next_cyc();
        bus.id_data_ready = 1'b1; bus.id_data_i = mk(99); #2;
        n_checks++; if (bus.lane_start !== 2'b01 || bus.lane_data_o !== mk(12)) begin n_err++; $display("FAIL full_disp got=%b/%h exp=01/%h", bus.lane_start, bus.lane_data_o, mk(12)); end
        next_cyc();
        bus.id_data_ready = 1'b0; #2;
        n_checks++; if (bus.occupancy !== 3'd4 || bus.drop_count !== 16'd2 || bus.overflow !== 1'b1) begin n_err++; $display("FAIL full_accept got=occ%0d/drop%0d/ovf%b exp=occ4/drop2/ovf1", bus.occupancy, bus.drop_count, bus.overflow); end
    endtask

    task automatic test_protocol();
        do_reset();
        bus.lane_done = 2'b10; bus.lane_data_i[1] = mk(5); #2;
        n_checks++; if (bus.ex_data_ready !== 1'b0) begin n_err++; $display("FAIL perr_no_retire_now got=%b exp=0", bus.ex_data_ready); end
        next_cyc();
        bus.lane_done = 2'b00; bus.id_data_ready = 1'b1; bus.id_data_i = mk(20); #2;
        n_checks++; if (bus.protocol_err !== 1'b1) begin n_err++; $display("FAIL perr_set got=%b exp=1", bus.protocol_err); end
        n_checks++; if (bus.ex_data_ready !== 1'b0 || bus.occupancy !== 3'd0) begin n_err++; $display("FAIL perr_no_effect got=%b/%0d exp=0/0", bus.ex_data_ready, bus.occupancy); end
        next_cyc();
        bus.id_data_ready = 1'b0; #2;
        n_checks++; if (bus.lane_start !== 2'b01 || bus.protocol_err !== 1'b1) begin n_err++; $display("FAIL perr_state_kept got=%b/%b exp=01/1", bus.lane_start, bus.protocol_err); end
        next_cyc(); next_cyc(); #2;
        n_checks++; if (bus.ex_data_ready !== 1'b0) begin n_err++; $display("FAIL perr_lane1_idle got=%b exp=0", bus.ex_data_ready); end
    endtask

    task automatic test_reset_mid();
        trace_output d;
        d = mk(40);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.id_data_ready = 1'b1; bus.id_data_i = mk(30 + i); next_cyc();
        end
        bus.id_data_ready = 1'b0; #2;
        n_checks++; if (bus.occupancy !== 3'd3) begin n_err++; $display("FAIL rmid_pre_occ got=%0d exp=3", bus.occupancy); end
        rst = 1'b0; #1;
        n_checks++; if ({bus.lane_start, bus.ex_data_ready, bus.occupancy} !== 6'd0) begin n_err++; $display("FAIL rmid_zero_ctrl got=%b exp=0", {bus.lane_start, bus.ex_data_ready, bus.occupancy}); end
        n_checks++; if ({bus.lane_data_o, bus.ex_data_o} !== '0) begin n_err++; $display("FAIL rmid_zero_data got=%h exp=0", {bus.lane_data_o, bus.ex_data_o}); end
        next_cyc();
        next_cyc();
        rst = 1'b1;
        bus.id_data_ready = 1'b1; bus.id_data_i = d; #2;
        n_checks++; if (bus.lane_start !== 2'b00) begin n_err++; $display("FAIL rmid_release_quiet got=%b exp=00", bus.lane_start); end
        next_cyc();
        bus.id_data_ready = 1'b0; #2;
        n_checks++; if (bus.lane_start !== 2'b01 || bus.lane_data_o !== d) begin n_err++; $display("FAIL rmid_disp_d got=%b/%h exp=01/%h", bus.lane_start, bus.lane_data_o, d); end
        next_cyc();
        bus.lane_done = 2'b01; bus.lane_data_i[0] = xf(d);
        next_cyc();
        bus.lane_done = 2'b00; #2;
        n_checks++; if (bus.ex_data_ready !== 1'b1 || bus.ex_data_o !== xf(d)) begin n_err++; $display("FAIL rmid_first_out got=%b/%h exp=1/%h", bus.ex_data_ready, bus.ex_data_o, xf(d)); end
    endtask

    // Model: a pending list and an in-flight list kept in program order; the next lane is
    // the dispatch count modulo NL and is free only if nothing in flight names it.
    task automatic test_random();
        trace_output    pq[$];
        infl_t          infl[$];
        int             disp_n, drops, nl, sz;
        bit             busy, exp_disp, exp_ret, idr;
        logic [NL-1:0]  dn, exp_start;
        disp_n = 0; drops = 0;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            dn = '0;
            for (int l = 0; l < NL; l++) begin
                bus.lane_data_i[l] = mk(int'($urandom_range(0, 999)));
                foreach (infl[k]) begin
                    if (infl[k].lane == l && !infl[k].done && $urandom_range(0, 2) == 0) begin
                        dn[l] = 1'b1;
                        bus.lane_data_i[l] = xf(infl[k].e);
                    end
                end
            end
            bus.lane_done     = dn;
            idr               = $urandom_range(0, 9) < 6;
            bus.id_data_ready = idr;
            bus.id_data_i     = mk(1000 + cyc);
            #2;
            nl = disp_n % NL;
            busy = 1'b0;
            foreach (infl[k]) if (infl[k].lane == nl) busy = 1'b1;
            exp_disp  = (pq.size() > 0) && !busy;
            exp_ret   = (infl.size() > 0) && infl[0].done;
            exp_start = '0;
            if (exp_disp) exp_start[nl] = 1'b1;
            n_checks++; if (bus.lane_start !== exp_start) begin n_err++; $display("FAIL rnd_start cyc=%0d got=%b exp=%b", cyc, bus.lane_start, exp_start); end
            if (exp_disp) begin
                n_checks++; if (bus.lane_data_o !== pq[0]) begin n_err++; $display("FAIL rnd_lane_data cyc=%0d got=%h exp=%h", cyc, bus.lane_data_o, pq[0]); end
            end
            n_checks++; if (bus.ex_data_ready !== exp_ret) begin n_err++; $display("FAIL rnd_ex_ready cyc=%0d got=%b exp=%b", cyc, bus.ex_data_ready, exp_ret); end
            if (exp_ret) begin
                n_checks++; if (bus.ex_data_o !== infl[0].r) begin n_err++; $display("FAIL rnd_ex_data cyc=%0d got=%h exp=%h", cyc, bus.ex_data_o, infl[0].r); end
            end
            n_checks++; if (bus.occupancy !== 3'(pq.size())) begin n_err++; $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", cyc, bus.occupancy, pq.size()); end
            sz = pq.size();
            if (exp_ret) void'(infl.pop_front());
            foreach (infl[k]) begin
                if (dn[infl[k].lane] && !infl[k].done) begin
                    infl[k].done = 1'b1;
                    infl[k].r    = xf(infl[k].e);
                end
            end
            if (exp_disp) begin
                infl.push_back('{e: pq[0], r: '0, lane: nl, done: 1'b0});
                void'(pq.pop_front());
                disp_n++;
            end
            if (idr) begin
                if (sz < QD || exp_disp) pq.push_back(mk(1000 + cyc));
                else drops++;
            end
            next_cyc();
        end
        clr_inputs(); #2;
        n_checks++; if (bus.drop_count !== 16'(drops)) begin n_err++; $display("FAIL rnd_drop_count got=%0d exp=%0d", bus.drop_count, drops); end
        n_checks++; if (bus.overflow !== (drops > 0)) begin n_err++; $display("FAIL rnd_overflow got=%b exp=%b", bus.overflow, drops > 0); end
        n_checks++; if (bus.protocol_err !== 1'b0) begin n_err++; $display("FAIL rnd_protocol_err got=%b exp=0", bus.protocol_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_order();
        test_overflow();
        test_full_accept();
        test_protocol();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
